// File: rtl/cpld_uart_pkg.sv
// cpld_uart_pkg: shared types and defaults for the CPLD UART.
//   CLKS_PER_BIT_DEFAULT : default clk cycles per serial bit
//   rx_state_t           : receiver FSM encoding
//   tx_state_t           : transmitter FSM encoding
package cpld_uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 16;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_t;

endpackage

// File: rtl/cpld_uart_rx.sv
// cpld_uart_rx: 8N1 receiver with 2-flop synchronizer and a holding register.
//   clk, rst     : system clock, async active-low reset
//   rxd          : raw serial input, idle high
//   read_done    : one-cycle pulse when the host completes a read
//   rx_hold      : holding register (last good byte)
//   data_ready   : holding register full
//   overrun_err  : sticky, an unread byte was overwritten
//   frame_err    : sticky, a stop bit sampled 0
//
// state    | meaning
// RX_IDLE  | waiting for synchronized rxd low
// RX_START | counting to start-bit midpoint, rejecting glitches
// RX_DATA  | sampling d0..d7 one bit period apart
// RX_STOP  | sampling the stop bit
module cpld_uart_rx
    import cpld_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       read_done,
    output logic [7:0] rx_hold,
    output logic       data_ready,
    output logic       overrun_err,
    output logic       frame_err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    rx_state_t   state, state_n;
    logic        rxd_meta, rxd_sync;
    logic [15:0] timer, timer_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift, shift_n;
    logic        load, stop_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta    <= 1'b1;
            rxd_sync    <= 1'b1;
            state       <= RX_IDLE;
            timer       <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            rx_hold     <= '0;
            data_ready  <= 1'b0;
            overrun_err <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            state    <= state_n;
            timer    <= timer_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            if (load) begin
                rx_hold <= shift;
            end
            // A load on the same edge as a read completion keeps the byte
            // ready and does not count as an overrun.
            if (load) begin
                data_ready <= 1'b1;
            end else if (read_done) begin
                data_ready <= 1'b0;
            end
            if (load && data_ready && !read_done) begin
                overrun_err <= 1'b1;
            end else if (read_done) begin
                overrun_err <= 1'b0;
            end
            if (stop_bad) begin
                frame_err <= 1'b1;
            end else if (read_done) begin
                frame_err <= 1'b0;
            end
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        load      = 1'b0;
        stop_bad  = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (!rxd_sync) begin
                    state_n = RX_START;
                    timer_n = HALF_LAST;
                end
            end
            RX_START: begin
                if (timer != 16'd0) begin
                    timer_n = timer - 16'd1;
                end else if (rxd_sync) begin
                    state_n = RX_IDLE;
                end else begin
                    state_n   = RX_DATA;
                    timer_n   = BIT_LAST;
                    bit_cnt_n = 3'd0;
                end
            end
            RX_DATA: begin
                if (timer != 16'd0) begin
                    timer_n = timer - 16'd1;
                end else begin
                    shift_n = {rxd_sync, shift[7:1]};
                    timer_n = BIT_LAST;
                    if (bit_cnt == 3'd7) begin
                        state_n = RX_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (timer != 16'd0) begin
                    timer_n = timer - 16'd1;
                end else begin
                    state_n  = RX_IDLE;
                    load     = rxd_sync;
                    stop_bad = !rxd_sync;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/cpld_uart.sv
// cpld_uart: CPLD-style UART, host bus plus 8N1 transmitter and receiver.
//   clk, rst     : system clock, async active-low reset
//   rdn, wrn     : host read / write strobes, active-low
//   data         : host bus, driven with the RX holding byte while rdn=0
//   data_ready   : RX holding register full
//   tbre, tsre   : TX buffer empty, TX shifter empty
//   overrun_err  : sticky RX overrun
//   frame_err    : sticky RX framing error
//   rxd, txd     : serial in / out, idle high
//
// state    | meaning
// TX_IDLE  | no frame on the line (tsre=1)
// TX_SHIFT | shifting start, d0..d7, stop
module cpld_uart
    import cpld_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdn,
    input  logic       wrn,
    inout  wire  [7:0] data,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       overrun_err,
    output logic       frame_err,
    input  logic       rxd,
    output logic       txd
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  STOP_IDX = 4'd9;

    tx_state_t   tx_state, tx_state_n;
    logic [7:0]  tx_buf, tx_buf_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic [3:0]  bit_idx, bit_idx_n;
    logic [15:0] tx_timer, tx_timer_n;
    logic        txd_n, tbre_n;
    logic        rdn_q, wrn_q;
    logic        write_accept, read_done, tx_load;
    logic [7:0]  rx_hold;

    assign write_accept = !wrn && wrn_q && tbre;
    assign read_done    = rdn && !rdn_q;
    assign tsre         = (tx_state == TX_IDLE);
    assign data         = (rst && !rdn) ? rx_hold : 8'bz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdn_q    <= 1'b1;
            wrn_q    <= 1'b1;
            tx_state <= TX_IDLE;
            tx_buf   <= '0;
            tx_shift <= '0;
            bit_idx  <= '0;
            tx_timer <= '0;
            txd      <= 1'b1;
            tbre     <= 1'b1;
        end else begin
            rdn_q    <= rdn;
            wrn_q    <= wrn;
            tx_state <= tx_state_n;
            tx_buf   <= tx_buf_n;
            tx_shift <= tx_shift_n;
            bit_idx  <= bit_idx_n;
            tx_timer <= tx_timer_n;
            txd      <= txd_n;
            tbre     <= tbre_n;
        end
    end

    // bit_idx: 0 = start bit, 1..8 = d0..d7, 9 = stop bit.
    always_comb begin
        tx_state_n = tx_state;
        tx_buf_n   = tx_buf;
        tx_shift_n = tx_shift;
        bit_idx_n  = bit_idx;
        tx_timer_n = tx_timer;
        txd_n      = txd;
        tbre_n     = tbre;
        tx_load    = 1'b0;

        if (write_accept) begin
            tx_buf_n = data;
            tbre_n   = 1'b0;
        end

        unique case (tx_state)
            TX_IDLE: begin
                tx_load = !tbre;
            end
            TX_SHIFT: begin
                if (tx_timer != 16'd0) begin
                    tx_timer_n = tx_timer - 16'd1;
                end else if (bit_idx == STOP_IDX) begin
                    // Back-to-back frames: a waiting byte starts on the
                    // edge that ends the stop bit.
                    if (tbre) begin
                        tx_state_n = TX_IDLE;
                    end else begin
                        tx_load = 1'b1;
                    end
                end else begin
                    bit_idx_n  = bit_idx + 4'd1;
                    tx_timer_n = BIT_LAST;
                    if (bit_idx < 4'd8) begin
                        txd_n      = tx_shift[0];
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                    end else begin
                        txd_n = 1'b1;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase

        // tx_load needs tbre=0 and write_accept needs tbre=1, so the two
        // never collide on the buffer.
        if (tx_load) begin
            tx_state_n = TX_SHIFT;
            tx_shift_n = tx_buf;
            bit_idx_n  = 4'd0;
            tx_timer_n = BIT_LAST;
            txd_n      = 1'b0;
            tbre_n     = 1'b1;
        end
    end

    cpld_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .read_done   (read_done),
        .rx_hold     (rx_hold),
        .data_ready  (data_ready),
        .overrun_err (overrun_err),
        .frame_err   (frame_err)
    );

endmodule

// File: tb/tb_cpld_uart.sv
// tb_cpld_uart: self-checking bench for cpld_uart (CLKS_PER_BIT=16).
// TX outputs are compared every cycle against a frame-time model; RX is
// checked per frame against a byte/flag model; directed cases pin both.
module tb_cpld_uart;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rdn = 1'b1;
    logic       wrn = 1'b1;
    logic       rxd = 1'b1;
    logic       drv_en = 1'b0;
    logic [7:0] drv_val = 8'h00;
    wire  [7:0] data;
    logic       data_ready, tbre, tsre, overrun_err, frame_err, txd;

    assign data = drv_en ? drv_val : 8'bz;

    cpld_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdn         (rdn),
        .wrn         (wrn),
        .data        (data),
        .data_ready  (data_ready),
        .tbre        (tbre),
        .tsre        (tsre),
        .overrun_err (overrun_err),
        .frame_err   (frame_err),
        .rxd         (rxd),
        .txd         (txd)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- TX model: buffer plus time-within-frame ----------------
    logic       m_buf_valid;
    logic [7:0] m_buf;
    logic       m_active;
    int         m_t;
    logic [7:0] m_byte;
    logic       m_wrn_prev;

    task automatic m_reset();
        m_buf_valid = 1'b0;
        m_buf       = 8'h00;
        m_active    = 1'b0;
        m_t         = 0;
        m_byte      = 8'h00;
        m_wrn_prev  = 1'b1;
    endtask

    task automatic m_step();
        logic full_before;
        full_before = m_buf_valid;
        if (m_active) begin
            m_t++;
            if (m_t == 10 * CPB) begin
                if (full_before) begin
                    m_byte      = m_buf;
                    m_t         = 0;
                    m_buf_valid = 1'b0;
                end else begin
                    m_active = 1'b0;
                end
            end
        end else if (full_before) begin
            m_active    = 1'b1;
            m_byte      = m_buf;
            m_t         = 0;
            m_buf_valid = 1'b0;
        end
        if (!wrn && m_wrn_prev && !full_before) begin
            m_buf_valid = 1'b1;
            m_buf       = data;
        end
        m_wrn_prev = wrn;
    endtask

    function automatic int exp_txd();
        int         b;
        logic [7:0] sh;
        if (!m_active) return 1;
        b = m_t / CPB;
        if (b == 0) return 0;
        if (b > 8) return 1;
        sh = m_byte >> (b - 1);
        return int'(sh[0]);
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("txd", int'(txd), exp_txd());
                check("tbre", int'(tbre), int'(!m_buf_valid));
                check("tsre", int'(tsre), int'(!m_active));
            end
        end
    end

    // ---------------- RX model: byte and flags per completed frame ----------
    logic       r_ready = 1'b0;
    logic [7:0] r_hold = 8'h00;
    logic       r_ovr = 1'b0;
    logic       r_ferr = 1'b0;

    task automatic rx_apply(input logic [7:0] b, input logic stop);
        if (stop) begin
            if (r_ready) r_ovr = 1'b1;
            r_hold  = b;
            r_ready = 1'b1;
        end else begin
            r_ferr = 1'b1;
        end
    endtask

    task automatic rx_read_clear();
        r_ready = 1'b0;
        r_ovr   = 1'b0;
        r_ferr  = 1'b0;
    endtask

    task automatic rx_check(input string tag);
        check({tag, "_data_ready"}, int'(data_ready), int'(r_ready));
        check({tag, "_overrun_err"}, int'(overrun_err), int'(r_ovr));
        check({tag, "_frame_err"}, int'(frame_err), int'(r_ferr));
    endtask

    // ---------------- stimulus helpers (all leave time at posedge+1) --------
    // Writes use odd cycles and reads even cycles so the bus never has two drivers.
    task automatic align(input int unsigned par);
        do begin
            @(posedge clk);
            #1;
        end while ((cyc % 2) != par);
    endtask

    task automatic host_write(input logic [7:0] b, input int extra);
        align(1);
        drv_val = b;
        drv_en  = 1'b1;
        wrn     = 1'b0;
        @(posedge clk);
        #1;
        drv_en = 1'b0;
        repeat (extra) begin
            @(posedge clk);
            #1;
        end
        wrn = 1'b1;
    endtask

    task automatic host_read(output logic [7:0] got, output logic ready_mid);
        align(0);
        rdn = 1'b0;
        @(negedge clk);
        got = data;
        @(posedge clk);
        #1;
        ready_mid = data_ready;
        rdn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[0];
            f   = f >> 1;
            repeat (CPB) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  got;
        logic        rh;
        int          n;
        int          tbre_low;
        int          tsre_low;
        int          txd_low;
        logic [9:0]  pat;
        int unsigned c0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", int'(txd), 1);
        check("rst_tbre", int'(tbre), 1);
        check("rst_tsre", int'(tsre), 1);
        check("rst_data_ready", int'(data_ready), 0);
        check("rst_overrun", int'(overrun_err), 0);
        check("rst_frame_err", int'(frame_err), 0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // TX 0x55: literal waveform
        host_write(8'h55, 0);
        tbre_low = tbre ? 0 : 1;
        tsre_low = 0;
        pat = '0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (!tbre) tbre_low++;
            if (!tsre) tsre_low++;
            if ((k - 1) % CPB == CPB / 2 && (k - 1) / CPB < 10) pat = {txd, pat[9:1]};
        end
        check("tx55_tbre_low_cycles", tbre_low, 1);
        check("tx55_tsre_low_cycles", tsre_low, 160);
        check("tx55_bit_pattern", int'(pat), 'h2AA);

        // RX 0xA3 with latency bound
        n = 0;
        fork
            send_frame(8'hA3, 1'b1);
            begin
                while (n < 170 && !data_ready) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join
        check("rxA3_latency_ok", int'(n <= 155), 1);
        rx_apply(8'hA3, 1'b1);
        rx_check("rxA3");
        host_read(got, rh);
        check("rxA3_read_data", int'(got), 'hA3);
        check("rxA3_ready_before_done", int'(rh), 1);
        check("rxA3_ready_after_done", int'(data_ready), 0);
        rx_read_clear();

        // Overrun: 0x11 then 0x22
        send_frame(8'h11, 1'b1);
        rx_apply(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        rx_apply(8'h22, 1'b1);
        check("ovr_flag_literal", int'(overrun_err), 1);
        rx_check("ovr");
        host_read(got, rh);
        check("ovr_read_data", int'(got), 'h22);
        rx_read_clear();
        check("ovr_cleared_ready", int'(data_ready), 0);
        check("ovr_cleared_overrun", int'(overrun_err), 0);

        // Framing error: 0x3C with stop 0, holding register untouched
        send_frame(8'h3C, 1'b0);
        rx_apply(8'h3C, 1'b0);
        check("ferr_flag_literal", int'(frame_err), 1);
        check("ferr_ready_literal", int'(data_ready), 0);
        rx_check("ferr");
        repeat (2 * CPB) @(posedge clk);
        #1;
        host_read(got, rh);
        check("ferr_hold_unchanged", int'(got), 'h22);
        rx_read_clear();
        check("ferr_cleared", int'(frame_err), 0);

        // Glitch of 4 cycles, then a real frame must still be received
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        rx_check("glitch");
        send_frame(8'h5A, 1'b1);
        rx_apply(8'h5A, 1'b1);
        rx_check("post_glitch");
        host_read(got, rh);
        check("post_glitch_data", int'(got), 'h5A);
        rx_read_clear();

        // Concurrent randomized TX writes and RX frames
        fork
            begin : tx_rand
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 220)) @(posedge clk);
                    host_write(8'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
                end
            end
            begin : rx_rand
                logic [7:0] b;
                logic       st;
                logic [7:0] rg;
                logic       rrh;
                for (int j = 0; j < 40; j++) begin
                    b  = 8'($urandom);
                    st = ($urandom_range(0, 4) != 0);
                    repeat ($urandom_range(1, 20)) @(posedge clk);
                    #1;
                    send_frame(b, st);
                    rx_apply(b, st);
                    rx_check("rand_frame");
                    if (!st) begin
                        repeat (CPB) @(posedge clk);
                        #1;
                    end
                    if ($urandom_range(0, 1) == 1) begin
                        host_read(rg, rrh);
                        check("rand_read_data", int'(rg), int'(r_hold));
                        check("rand_read_ready", int'(rrh), int'(r_ready));
                        rx_read_clear();
                        rx_check("rand_after_read");
                    end
                end
            end
        join

        n = 0;
        while ((!tbre || !tsre) && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tx_drained", int'(tbre && tsre), 1);

        // Reset mid-frame with a byte waiting
        host_write(8'h01, 0);
        c0 = cyc;
        host_write(8'h02, 0);
        check("pre_rst_buffered", int'(tbre), 0);
        while (cyc - c0 < 50) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_txd_d2", int'(txd), 0);
        rst = 1'b0;
        #1;
        check("midrst_txd", int'(txd), 1);
        check("midrst_tbre", int'(tbre), 1);
        check("midrst_tsre", int'(tsre), 1);
        check("midrst_data_ready", int'(data_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        txd_low = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (!txd) txd_low++;
        end
        check("no_send_after_rst", txd_low, 0);
        check("post_rst_tbre", int'(tbre), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpld_uart.md
CPLD_UART -- requirements
Module: cpld_uart

Interface
REQ-001 SHALL: CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 4..65535, even values only.
REQ-002 SHALL: clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL: rdn  input  1  host read strobe, active-low, synchronous to clk.
REQ-005 SHALL: wrn  input  1  host write strobe, active-low, synchronous to clk.
REQ-006 SHALL: data  inout  8  host bus; driven with the RX holding byte while rdn=0, else high-Z.
REQ-007 SHALL: data_ready  output  1  RX holding register full.
REQ-008 SHALL: tbre  output  1  TX buffer register empty.
REQ-009 SHALL: tsre  output  1  TX shift register empty; high when no frame is on the line.
REQ-010 SHALL: overrun_err  output  1  sticky; unread byte was overwritten.
REQ-011 SHALL: frame_err  output  1  sticky; a received stop bit sampled 0.
REQ-012 SHALL: rxd  input  1  serial in, asynchronous, idle high.
REQ-013 SHALL: txd  output  1  serial out, idle high; 8N1 frame, LSB first.

Function
REQ-014 SHALL: write accept: rising edge E0 where wrn=0 and wrn was 1 on the previous edge, with tbre=1; data latched into TX buffer at E0; tbre=0 after E0.
REQ-015 SHALL: a write falling edge while tbre=0 is ignored; buffer and tbre are unchanged.
REQ-016 SHALL: buffer-to-shifter transfer on the first edge with tbre=0 and tsre=1; after it tbre=1, tsre=0, txd=0 (start bit).
REQ-017 SHALL: TX frame: start bit, d0..d7, stop bit (1), each exactly CLKS_PER_BIT cycles; tsre=1 on the edge ending the stop bit.
REQ-018 SHALL: a byte accepted while a frame shifts waits in the buffer and starts on the edge ending the current stop bit, giving no idle gap.
REQ-019 SHALL: rxd passes a 2-flop synchronizer; RX FSM states are IDLE, START, DATA, STOP.
REQ-020 SHALL: IDLE->START on synchronized rxd=0; START checks at CLKS_PER_BIT/2; if 1, return to IDLE (glitch); if 0, go to DATA.
REQ-021 SHALL: DATA samples 8 bits at CLKS_PER_BIT intervals from the start-bit midpoint; STOP samples one further interval later, then returns to IDLE.
REQ-022 SHALL: stop bit=1 loads the holding register and sets data_ready=1; if data_ready was already 1, the byte overwrites it and sets overrun_err.
REQ-023 SHALL: stop bit=0 discards the byte, sets frame_err, and leaves the holding register and data_ready unchanged.
REQ-024 SHALL: read completion is the first edge with rdn=1 after rdn=0; data_ready, overrun_err and frame_err clear after that edge.
REQ-025 SHALL: when a load and a read completion fall on the same edge, the load wins: data_ready stays 1 and overrun_err is not set.
REQ-026 SHALL: TX and RX operate independently and concurrently; rdn=0 and wrn=0 together are both honoured.

Reset
REQ-027 SHALL: while rst=0: txd=1, tbre=1, tsre=1, data_ready=0, overrun_err=0, frame_err=0, data high-Z, both FSMs idle, holding register 0x00.
REQ-028 SHALL: reset mid-frame aborts the frame immediately; txd returns to 1 with no partial stop bit.

Structure
REQ-029 SHALL: package cpld_uart_pkg holds the RX and TX state enums and the CLKS_PER_BIT default.
REQ-030 SHALL: the receiver (synchronizer, RX FSM, holding register) is sub-module cpld_uart_rx; TX and bus logic stay in the top level.

Verification (CLKS_PER_BIT=16)
REQ-031 SHALL: wrn low 1 cycle with data=0x55 -> tbre low 1 cycle; tsre low 160 cycles; txd levels 0,1,0,1,0,1,0,1,0,1, each 16 cycles.
REQ-032 SHALL: rxd frame 0xA3 -> data_ready=1 within 9.5 bit times + 3 cycles; rdn=0 -> data=0xA3; rdn=1 -> data_ready=0 after the next edge.
REQ-033 SHALL: frames 0x11 then 0x22 with no read -> read returns 0x22 and overrun_err=1; both flags are 0 after read completion.
REQ-034 SHALL: frame 0x3C with stop bit 0 -> frame_err=1, data_ready stays 0.
REQ-035 SHALL: rxd low pulse of 4 cycles -> no load, no flag change, RX FSM back in IDLE.
REQ-036 SHALL: writes 0x01, then 0x02 during that frame, then rst=0 at cycle 50 -> txd=1, tbre=1, tsre=1 immediately, and 0x02 is never sent.
